// File: rtl/mtpsa_digest_split.sv
// Register slice that strips the 256-bit digest from tuser and diverts {user_id, src_port, digest}
// of flagged packets into a small FIFO for the CPU path. state | meaning: SOF | next beat starts a packet, BODY | inside a packet
module mtpsa_digest_split #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 304,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int DIGEST_WIDTH         = 256,
  parameter int FIFO_DEPTH_LOG2      = 3
) (
  input  logic                              axis_aclk,
  input  logic                              axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [DIGEST_WIDTH+15:0]          dig_tdata,
  output logic                              dig_tvalid,
  input  logic                              dig_tready,
  output logic [FIFO_DEPTH_LOG2:0]          dig_level,
  output logic [31:0]                       stat_pkt_cnt,
  output logic [31:0]                       stat_dig_cnt,
  output logic [31:0]                       stat_dig_drop
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W = DIGEST_WIDTH + 16;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LVL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE  = (FIFO_DEPTH_LOG2+1)'(1);

  typedef enum logic {ST_SOF = 1'b0, ST_BODY = 1'b1} state_t;

  state_t state, state_nxt;
  logic   sof;
  logic   m_valid_r;
  logic   s_hs;

  assign s_axis_tready = !m_valid_r || m_axis_tready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = m_valid_r;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      m_valid_r    <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else if (s_hs) begin
      m_valid_r    <= 1'b1;
      m_axis_tdata <= s_axis_tdata;
      m_axis_tkeep <= s_axis_tkeep;
      m_axis_tuser <= {{(C_M_AXIS_TUSER_WIDTH-48){1'b0}}, s_axis_tuser[47:0]};
      m_axis_tlast <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_valid_r <= 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) state <= ST_SOF;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SOF:  if (s_hs && !s_axis_tlast) state_nxt = ST_BODY;
      ST_BODY: if (s_hs && s_axis_tlast)  state_nxt = ST_SOF;
      default: state_nxt = ST_SOF;
    endcase
  end

  always_comb begin
    sof = (state == ST_SOF);
  end

  // Digest FIFO: N+1 bit pointers so level==DEPTH is distinguishable from empty.
  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0]   wptr, rptr;
  logic                       full, push_req, do_push, do_pop;

  assign dig_level  = wptr - rptr;
  assign dig_tvalid = (dig_level != '0);
  assign full       = (dig_level == FULL_LVL);
  assign push_req   = s_hs && sof && s_axis_tuser[32];
  assign do_push    = push_req && !full;
  assign do_pop     = dig_tvalid && dig_tready;
  assign dig_tdata  = dig_tvalid ? mem[rptr[FIFO_DEPTH_LOG2-1:0]] : '0;

  always_ff @(posedge axis_aclk) begin
    if (do_push)
      mem[wptr[FIFO_DEPTH_LOG2-1:0]] <= {s_axis_tuser[47:40], s_axis_tuser[23:16],
                                         s_axis_tuser[48 +: DIGEST_WIDTH]};
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      stat_pkt_cnt  <= '0;
      stat_dig_cnt  <= '0;
      stat_dig_drop <= '0;
    end else begin
      if (s_hs && s_axis_tlast && stat_pkt_cnt != '1) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      if (do_push && stat_dig_cnt != '1)              stat_dig_cnt <= stat_dig_cnt + 32'd1;
      if (push_req && full && stat_dig_drop != '1)    stat_dig_drop <= stat_dig_drop + 32'd1;
    end
  end

endmodule

// File: tb/tb_mtpsa_digest_split.sv
// Randomized bench for mtpsa_digest_split against a queue-based packet/digest reference model.
module tb_mtpsa_digest_split;
  localparam int DEPTH = 8;

  logic         axis_aclk = 1'b0;
  logic         axis_rst;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [303:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [271:0] dig_tdata;
  logic         dig_tvalid, dig_tready;
  logic [3:0]   dig_level;
  logic [31:0]  stat_pkt_cnt, stat_dig_cnt, stat_dig_drop;

  mtpsa_digest_split dut (
    .axis_aclk(axis_aclk), .axis_rst(axis_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .dig_tdata(dig_tdata), .dig_tvalid(dig_tvalid), .dig_tready(dig_tready), .dig_level(dig_level),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_dig_cnt(stat_dig_cnt), .stat_dig_drop(stat_dig_drop)
  );

  always #5 axis_aclk = ~axis_aclk;

  int errors = 0;
  int checks = 0;

  // Reference model: digest queue, counters, packet position and the single output slot.
  logic [271:0] dq[$];
  int           exp_pkt, exp_dig, exp_drop;
  bit           in_pkt;
  bit           mv;
  logic [255:0] md;
  logic [31:0]  mk;
  logic [47:0]  mu;
  bit           ml;

  function automatic logic [303:0] mk_tuser(input logic [15:0] len, input logic [7:0] src,
      input logic [7:0] dst, input logic [7:0] sd, input logic [7:0] uid, input logic [255:0] dig);
    return {dig, uid, sd, dst, src, len};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [303:0] garbage_tuser();
    logic [303:0] u;
    u = {rnd256(), 16'($urandom), 32'($urandom)};
    u[32] = 1'b1;
    return u;
  endfunction

  task automatic model_clear();
    dq.delete();
    exp_pkt = 0; exp_dig = 0; exp_drop = 0;
    in_pkt = 0; mv = 0; md = '0; mk = '0; mu = '0; ml = 0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic tick(input bit v, input logic [255:0] d, input logic [303:0] u, input bit l,
                      input bit mr, input bit dr, output bit hs);
    bit pop;
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tkeep = d[255:224]; s_axis_tuser = u;
    s_axis_tlast = l; m_axis_tready = mr; dig_tready = dr;
    hs  = v && (!mv || mr);
    pop = dr && (dq.size() > 0);
    @(posedge axis_aclk);
    if (hs) begin
      if (!in_pkt && u[32]) begin
        if (dq.size() < DEPTH) begin
          dq.push_back({u[47:40], u[23:16], u[303:48]});
          exp_dig++;
        end else exp_drop++;
      end
      if (l) exp_pkt++;
      in_pkt = !l;
    end
    if (pop) void'(dq.pop_front());
    if (hs) begin
      mv = 1; md = d; mk = d[255:224]; mu = u[47:0]; ml = l;
    end else if (mr) mv = 0;
    @(negedge axis_aclk);
  endtask

  task automatic idle(input bit mr, input bit dr);
    bit hs;
    tick(1'b0, '0, '0, 1'b0, mr, dr, hs);
  endtask

  task automatic do_reset();
    axis_rst = 1; s_axis_tvalid = 0; m_axis_tready = 1; dig_tready = 0;
    @(posedge axis_aclk);
    model_clear();
    @(negedge axis_aclk);
    axis_rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (dig_tvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b want 0", dig_tvalid); end
    checks++; if (dig_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", dig_level); end
    checks++; if ({stat_pkt_cnt, stat_dig_cnt, stat_dig_drop} !== 96'd0) begin errors++; $display("FAIL reset_stats: got %h want 0", {stat_pkt_cnt, stat_dig_cnt, stat_dig_drop}); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %b want 1", s_axis_tready); end
    checks++; if ({m_axis_tdata, m_axis_tuser, dig_tdata} !== '0) begin errors++; $display("FAIL reset_data: nonzero outputs after reset"); end
  endtask

  task automatic test_single_beat();
    bit hs;
    logic [255:0] d;
    d = rnd256();
    tick(1'b1, d, mk_tuser(16'd64, 8'h01, 8'h04, 8'h01, 8'h05, {32{8'hA5}}), 1'b1, 1'b1, 1'b0, hs);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL sb_mvalid: got %b want 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== d) begin errors++; $display("FAIL sb_tdata: got %h want %h", m_axis_tdata, d); end
    checks++; if (m_axis_tuser !== 128'h0000_0000_0000_0000_0000_0501_0401_0040) begin errors++; $display("FAIL sb_tuser: got %h want 0x050104010040", m_axis_tuser); end
    checks++; if (dig_tdata !== {8'h05, 8'h01, {32{8'hA5}}}) begin errors++; $display("FAIL sb_digest: got %h", dig_tdata); end
    checks++; if (dig_level !== 4'd1) begin errors++; $display("FAIL sb_level: got %0d want 1", dig_level); end
    checks++; if (stat_pkt_cnt !== 32'd1 || stat_dig_cnt !== 32'd1) begin errors++; $display("FAIL sb_stats: got pkt=%0d dig=%0d want 1 1", stat_pkt_cnt, stat_dig_cnt); end
    idle(1'b1, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL sb_mvalid_clear: got %b want 0", m_axis_tvalid); end
    checks++; if (dig_level !== 4'd0) begin errors++; $display("FAIL sb_pop_level: got %0d want 0", dig_level); end
  endtask

  task automatic test_multibeat();
    bit hs;
    logic [303:0] u;
    int dig0;
    dig0 = exp_dig;
    for (int b = 0; b < 4; b++) begin
      u = (b == 0) ? mk_tuser(16'd128, 8'h02, 8'h03, 8'h01, 8'h07, rnd256()) : garbage_tuser();
      tick(1'b1, rnd256(), u, b == 3, 1'b1, 1'b0, hs);
      checks++; if (m_axis_tdata !== md || m_axis_tkeep !== mk || m_axis_tlast !== ml) begin errors++; $display("FAIL mb_beat%0d: got %h want %h", b, m_axis_tdata, md); end
      checks++; if (m_axis_tuser !== {80'b0, mu}) begin errors++; $display("FAIL mb_tuser%0d: got %h want %h", b, m_axis_tuser, {80'b0, mu}); end
    end
    checks++; if (stat_dig_cnt !== 32'(dig0 + 1)) begin errors++; $display("FAIL mb_one_digest: got %0d want %0d", stat_dig_cnt, dig0 + 1); end
    checks++; if (dig_level !== 4'd1) begin errors++; $display("FAIL mb_level: got %0d want 1", dig_level); end
    // A new flagged packet right after tlast proves the packet tracker is back at start-of-frame.
    tick(1'b1, rnd256(), mk_tuser(16'd60, 8'h09, 8'h01, 8'h01, 8'h0A, rnd256()), 1'b1, 1'b1, 1'b0, hs);
    checks++; if (stat_dig_cnt !== 32'(dig0 + 2)) begin errors++; $display("FAIL mb_sof_return: got %0d want %0d", stat_dig_cnt, dig0 + 2); end
    for (int i = 0; i < 4 && dq.size() > 0; i++) begin
      checks++; if (dig_tdata !== dq[0]) begin errors++; $display("FAIL mb_pop%0d: got %h want %h", i, dig_tdata, dq[0]); end
      idle(1'b1, 1'b1);
    end
    checks++; if (dig_level !== 4'd0 || stat_pkt_cnt !== 32'(exp_pkt)) begin errors++; $display("FAIL mb_end: level=%0d pkt=%0d want 0 %0d", dig_level, stat_pkt_cnt, exp_pkt); end
  endtask

  task automatic test_stall();
    logic [255:0] sent[5];
    logic [255:0] got[$];
    int idx, stall;
    bit mr, hs;
    for (int i = 0; i < 5; i++) sent[i] = rnd256();
    idx = 0; stall = 0;
    for (int c = 0; c < 60 && idx < 5; c++) begin
      mr = !(idx >= 2 && stall < 5);
      if (!mr) stall++;
      m_axis_tready = mr;
      s_axis_tvalid = 1'b1;
      #1;
      checks++; if (s_axis_tready !== (!mv || mr)) begin errors++; $display("FAIL st_sready c%0d: got %b want %b", c, s_axis_tready, !mv || mr); end
      if (mv) begin
        checks++; if (m_axis_tdata !== md) begin errors++; $display("FAIL st_hold c%0d: got %h want %h", c, m_axis_tdata, md); end
      end
      if (m_axis_tvalid && mr) got.push_back(m_axis_tdata);
      tick(1'b1, sent[idx], mk_tuser(16'd256, 8'h01, 8'h02, 8'h00, 8'h00, '0), idx == 4, mr, 1'b0, hs);
      if (hs) idx++;
    end
    for (int c = 0; c < 3; c++) begin
      m_axis_tready = 1'b1; s_axis_tvalid = 1'b0;
      #1;
      if (m_axis_tvalid) got.push_back(m_axis_tdata);
      idle(1'b1, 1'b0);
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL st_count: got %0d beats want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL st_order%0d: got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  logic [271:0] fill_sent[10];

  task automatic test_fifo_fill();
    bit hs;
    logic [303:0] u;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      u = mk_tuser(16'($urandom), 8'($urandom), 8'($urandom), 8'h01, 8'($urandom), rnd256());
      fill_sent[i] = {u[47:40], u[23:16], u[303:48]};
      tick(1'b1, rnd256(), u, 1'b1, 1'b1, 1'b0, hs);
    end
    checks++; if (dig_level !== 4'd8) begin errors++; $display("FAIL ff_level: got %0d want 8", dig_level); end
    checks++; if (stat_dig_cnt !== 32'd8 || stat_dig_drop !== 32'd2) begin errors++; $display("FAIL ff_stats: got dig=%0d drop=%0d want 8 2", stat_dig_cnt, stat_dig_drop); end
    checks++; if (dig_tdata !== fill_sent[0]) begin errors++; $display("FAIL ff_head: got %h want %h", dig_tdata, fill_sent[0]); end
  endtask

  task automatic test_full_push_pop();
    bit hs;
    tick(1'b1, rnd256(), mk_tuser(16'd99, 8'h03, 8'h03, 8'h01, 8'h33, rnd256()), 1'b1, 1'b1, 1'b1, hs);
    checks++; if (dig_level !== 4'd7) begin errors++; $display("FAIL fp_level: got %0d want 7", dig_level); end
    checks++; if (stat_dig_drop !== 32'd3 || stat_dig_cnt !== 32'd8) begin errors++; $display("FAIL fp_stats: got drop=%0d dig=%0d want 3 8", stat_dig_drop, stat_dig_cnt); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (dig_tdata !== fill_sent[i]) begin errors++; $display("FAIL fp_order%0d: got %h want %h", i, dig_tdata, fill_sent[i]); end
      idle(1'b1, 1'b1);
    end
    checks++; if (dig_tvalid !== 1'b0 || dig_level !== 4'(dq.size())) begin errors++; $display("FAIL fp_empty: valid=%b level=%0d want 0 0", dig_tvalid, dig_level); end
  endtask

  task automatic test_reset_mid_packet();
    bit hs;
    logic [303:0] u;
    for (int i = 0; i < 3; i++)
      tick(1'b1, rnd256(), mk_tuser(16'd64, 8'($urandom), 8'h01, 8'h01, 8'($urandom), rnd256()), 1'b1, 1'b1, 1'b0, hs);
    tick(1'b1, rnd256(), mk_tuser(16'd200, 8'h04, 8'h02, 8'h00, 8'h11, rnd256()), 1'b0, 1'b1, 1'b0, hs);
    tick(1'b1, rnd256(), garbage_tuser(), 1'b0, 1'b1, 1'b0, hs);
    checks++; if (dig_level !== 4'd3) begin errors++; $display("FAIL rm_pre_level: got %0d want 3", dig_level); end
    do_reset();
    checks++; if ({m_axis_tvalid, m_axis_tlast, dig_tvalid} !== 3'b000 || dig_level !== 4'd0) begin errors++; $display("FAIL rm_flags: mvalid=%b dvalid=%b level=%0d want 0", m_axis_tvalid, dig_tvalid, dig_level); end
    checks++; if ({m_axis_tdata, m_axis_tuser, dig_tdata, stat_pkt_cnt, stat_dig_cnt, stat_dig_drop} !== '0) begin errors++; $display("FAIL rm_zero: outputs not cleared by reset"); end
    u = mk_tuser(16'd300, 8'h06, 8'h02, 8'h01, 8'h44, rnd256());
    tick(1'b1, rnd256(), u, 1'b0, 1'b1, 1'b0, hs);
    checks++; if (dig_level !== 4'd1 || stat_dig_cnt !== 32'd1) begin errors++; $display("FAIL rm_push: level=%0d dig=%0d want 1 1", dig_level, stat_dig_cnt); end
    checks++; if (dig_tdata !== {8'h44, 8'h06, u[303:48]}) begin errors++; $display("FAIL rm_entry: got %h", dig_tdata); end
    tick(1'b1, rnd256(), garbage_tuser(), 1'b1, 1'b1, 1'b0, hs);
    checks++; if (dig_level !== 4'(dq.size()) || stat_pkt_cnt !== 32'd1) begin errors++; $display("FAIL rm_tail: level=%0d pkt=%0d want %0d 1", dig_level, stat_pkt_cnt, dq.size()); end
  endtask

  initial begin
    axis_rst = 1; s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tlast = 0; m_axis_tready = 1; dig_tready = 0;
    model_clear();
    @(negedge axis_aclk);
    test_reset();
    test_single_beat();
    test_multibeat();
    test_stall();
    test_fifo_fill();
    test_full_push_pop();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
